// File: rtl/e_elev_pkg.sv
// Shared elevator types: controller state encoding, floor-count default and
// one-hot floor mask helpers used by the trip scheduler.
package e_elev_pkg;

  localparam int NFLOORS_DEF = 4;
  localparam int FLR_MAX     = 32;

  typedef logic [FLR_MAX-1:0] flr_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DWELL  = 2'd2
  } state_t;

  // Floors strictly above the one-hot position.
  function automatic flr_vec_t above_mask(input flr_vec_t onehot);
    return ~((onehot << 1) - flr_vec_t'(1));
  endfunction

  // Floors strictly below the one-hot position.
  function automatic flr_vec_t below_mask(input flr_vec_t onehot);
    return onehot - flr_vec_t'(1);
  endfunction

endpackage

// File: rtl/e_down_counter.sv
// Loadable down-counter that holds at zero; load wins over decrement.
// zero is a pure decode of the registered count.
module e_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/e_trip_scheduler.sv
// Elevator car sequencer: latches requests, SCAN direction choice, travel and
// door-dwell timing, one-hot floor tracking; motor/door outputs decode registered state.
module e_trip_scheduler
  import e_elev_pkg::*;
#(
  parameter int NFLOORS    = NFLOORS_DEF,
  parameter int TRAVEL_CYC = 8,
  parameter int DOOR_CYC   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] req,
  output logic [NFLOORS-1:0] cur_flr,
  output logic [NFLOORS-1:0] pending,
  output logic               dir,
  output logic               m_up,
  output logic               m_dn,
  output logic               door_open,
  output logic               arrive,
  output logic               busy
);

  localparam int CMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  state_t             state, state_nxt;
  logic [NFLOORS-1:0] eff, above, below, ahead, behind, nxt_flr, clr, lat;
  logic               here_hit, next_hit, dir_nxt, step;
  logic               trv_load, trv_zero, dwl_load, dwl_zero;

  assign eff      = pending | req;
  assign above    = NFLOORS'(above_mask(flr_vec_t'(cur_flr)));
  assign below    = NFLOORS'(below_mask(flr_vec_t'(cur_flr)));
  assign ahead    = eff & (dir ? above : below);
  assign behind   = eff & (dir ? below : above);
  assign nxt_flr  = dir ? (cur_flr << 1) : (cur_flr >> 1);
  assign here_hit = |(eff & cur_flr);
  assign next_hit = |(eff & nxt_flr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    trv_load  = 1'b0;
    dwl_load  = 1'b0;
    step      = 1'b0;
    clr       = '0;
    case (state)
      IDLE: begin
        if (here_hit) begin
          state_nxt = DWELL;
          dwl_load  = 1'b1;
          clr       = cur_flr;
        end else if (|eff) begin
          state_nxt = MOVING;
          trv_load  = 1'b1;
          dir_nxt   = (|ahead) ? dir : ~dir;
        end
      end
      MOVING: begin
        if (trv_zero) begin
          step = 1'b1;
          if (next_hit) begin
            state_nxt = DWELL;
            dwl_load  = 1'b1;
            clr       = nxt_flr;
          end else begin
            trv_load = 1'b1;
          end
        end
      end
      DWELL: begin
        // A call at the current floor holds the door rather than queueing.
        if (|(req & cur_flr)) begin
          dwl_load = 1'b1;
        end else if (dwl_zero) begin
          if (|ahead) begin
            state_nxt = MOVING;
            trv_load  = 1'b1;
          end else if (|behind) begin
            state_nxt = MOVING;
            trv_load  = 1'b1;
            dir_nxt   = ~dir;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_up      = (state == MOVING) &&  dir;
    m_dn      = (state == MOVING) && !dir;
    door_open = (state == DWELL);
    busy      = (state != IDLE);
  end

  assign lat = (state == DWELL) ? (req & ~cur_flr) : req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_flr <= NFLOORS'(1);
      pending <= '0;
      dir     <= 1'b1;
      arrive  <= 1'b0;
    end else begin
      cur_flr <= step ? nxt_flr : cur_flr;
      pending <= (pending | lat) & ~clr;
      dir     <= dir_nxt;
      arrive  <= step;
    end
  end

  e_down_counter #(.W(CW)) u_travel (
    .clk      (clk),
    .rst      (rst),
    .load     (trv_load),
    .load_val (CW'(TRAVEL_CYC - 1)),
    .dec      (state == MOVING),
    .zero     (trv_zero)
  );

  e_down_counter #(.W(CW)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (dwl_load),
    .load_val (CW'(DOOR_CYC - 1)),
    .dec      (state == DWELL),
    .zero     (dwl_zero)
  );

endmodule

// File: tb/tb_e_trip_scheduler.sv
// Directed bench for e_trip_scheduler with NFLOORS=4, TRAVEL_CYC=2, DOOR_CYC=3.
module tb_e_trip_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] cur_flr, pending;
  logic       dir, m_up, m_dn, door_open, arrive, busy;

  int vecs = 0;
  int errs = 0;

  e_trip_scheduler #(.NFLOORS(4), .TRAVEL_CYC(2), .DOOR_CYC(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .cur_flr   (cur_flr),
    .pending   (pending),
    .dir       (dir),
    .m_up      (m_up),
    .m_dn      (m_dn),
    .door_open (door_open),
    .arrive    (arrive),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    repeat (3) step();
    vecs++;
    if ({cur_flr, pending, dir, m_up, m_dn, door_open, arrive, busy} !== {4'b0001, 4'b0000, 1'b1, 5'b00000}) begin
      errs++;
      $display("FAIL reset_state: got %b want %b", {cur_flr, pending, dir, m_up, m_dn, door_open, arrive, busy}, {4'b0001, 4'b0000, 1'b1, 5'b00000});
    end
    rst = 1'b0;
    repeat (5) step();
    vecs++;
    if ({cur_flr, pending, dir, m_up, m_dn, door_open, arrive, busy} !== {4'b0001, 4'b0000, 1'b1, 5'b00000}) begin
      errs++;
      $display("FAIL reset_idle: got %b want %b", {cur_flr, pending, dir, m_up, m_dn, door_open, arrive, busy}, {4'b0001, 4'b0000, 1'b1, 5'b00000});
    end
  endtask

  task automatic test_same_floor();
    int ndoor = 0, nmot = 0, npend = 0;
    req = 4'b0001;
    step();
    req = '0;
    for (int k = 0; k < 40 && busy; k++) begin
      if (door_open) ndoor++;
      if (m_up || m_dn) nmot++;
      if (pending != 4'b0000) npend++;
      step();
    end
    vecs++;
    if (ndoor !== 3) begin errs++; $display("FAIL same_floor_door: got %0d want 3", ndoor); end
    vecs++;
    if ({nmot, npend} !== {32'd0, 32'd0}) begin
      errs++; $display("FAIL same_floor_motor_pending: motor %0d pending %0d want 0 0", nmot, npend);
    end
    vecs++;
    if ({busy, cur_flr} !== {1'b0, 4'b0001}) begin
      errs++; $display("FAIL same_floor_end: got %b want %b", {busy, cur_flr}, 5'b00001);
    end
  endtask

  task automatic test_single_trip();
    int nup = 0, ndn = 0, narr = 0, ndoor = 0, bad = 0, cyc;
    logic prev_door = 1'b0;
    req = 4'b1000;
    step();
    req = '0;
    for (int k = 0; k < 60 && busy; k++) begin
      if (m_up) nup++;
      if (m_dn) ndn++;
      if (arrive) narr++;
      if (door_open) ndoor++;
      if (door_open && !prev_door && !arrive) bad++;
      if ({$onehot(cur_flr), m_up & m_dn} !== 2'b10) bad++;
      prev_door = door_open;
      step();
    end
    vecs++;
    if ({nup, narr, ndoor, ndn} !== {32'd6, 32'd3, 32'd3, 32'd0}) begin
      errs++; $display("FAIL trip_counts: up %0d arrive %0d door %0d dn %0d want 6 3 3 0", nup, narr, ndoor, ndn);
    end
    vecs++;
    if (bad !== 0) begin errs++; $display("FAIL trip_sanity: got %0d violations want 0", bad); end
    vecs++;
    if ({busy, cur_flr, pending} !== {1'b0, 4'b1000, 4'b0000}) begin
      errs++; $display("FAIL trip_end: got %b want %b", {busy, cur_flr, pending}, 9'b0_1000_0000);
    end
    // Call at the top floor while parked there: door opens, car stays put.
    req = 4'b1000;
    step();
    req = '0;
    vecs++;
    if ({m_up, m_dn, door_open, cur_flr} !== {3'b001, 4'b1000}) begin
      errs++; $display("FAIL top_boundary: got %b want %b", {m_up, m_dn, door_open, cur_flr}, 7'b0011000);
    end
    run_to_idle(cyc);
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL top_boundary_idle: busy %b want 0", busy); end
  endtask

  task automatic test_scan();
    int stops[4];
    int nstop = 0, early_dn = 0, bad = 0, cyc;
    logic served3 = 1'b0, prev_door = 1'b0;
    req = 4'b0001;
    step();
    req = '0;
    run_to_idle(cyc);
    vecs++;
    if ({busy, cur_flr} !== {1'b0, 4'b0001}) begin
      errs++; $display("FAIL scan_home: got %b want %b", {busy, cur_flr}, 5'b00001);
    end
    for (int k = 0; k < 200; k++) begin
      req = (k == 0) ? 4'b1000 : (k == 1) ? 4'b0001 : (k == 3) ? 4'b0100 : 4'b0000;
      step();
      if (k == 2) begin
        vecs++;
        if ({cur_flr, pending, m_up} !== {4'b0010, 4'b1001, 1'b1}) begin
          errs++; $display("FAIL scan_setup: got %b want %b", {cur_flr, pending, m_up}, 9'b0010_1001_1);
        end
      end
      if (door_open && !prev_door) begin
        if (nstop < 4) stops[nstop] = $clog2(cur_flr);
        nstop++;
        if (cur_flr == 4'b1000) served3 = 1'b1;
      end
      if (m_dn && !served3) early_dn++;
      if ({$onehot(cur_flr), m_up & m_dn} !== 2'b10) bad++;
      prev_door = door_open;
      if (!busy) break;
    end
    vecs++;
    if (nstop !== 3) begin errs++; $display("FAIL scan_nstops: got %0d want 3", nstop); end
    else begin
      vecs++;
      if ({stops[0], stops[1], stops[2]} !== {32'd2, 32'd3, 32'd0}) begin
        errs++; $display("FAIL scan_order: got %0d %0d %0d want 2 3 0", stops[0], stops[1], stops[2]);
      end
    end
    vecs++;
    if ({early_dn, bad} !== {32'd0, 32'd0}) begin
      errs++; $display("FAIL scan_early_down: early %0d sanity %0d want 0 0", early_dn, bad);
    end
    vecs++;
    if ({busy, cur_flr, pending} !== {1'b0, 4'b0001, 4'b0000}) begin
      errs++; $display("FAIL scan_end: got %b want %b", {busy, cur_flr, pending}, 9'b0_0001_0000);
    end
  endtask

  task automatic test_door_hold();
    int ndoor = 0, npbit = 0, nmot = 0;
    for (int k = 0; k < 60; k++) begin
      req = (k < 11) ? 4'b0001 : 4'b0000;
      step();
      if (door_open) ndoor++;
      if (pending[0]) npbit++;
      if (m_up || m_dn) nmot++;
      if (!busy) break;
    end
    req = '0;
    vecs++;
    if (ndoor !== 13) begin errs++; $display("FAIL hold_door: got %0d want 13", ndoor); end
    vecs++;
    if ({npbit, nmot} !== {32'd0, 32'd0}) begin
      errs++; $display("FAIL hold_pending_motor: pbit %0d motor %0d want 0 0", npbit, nmot);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    req = 4'b1000;
    step();
    req = '0;
    run_to_idle(cyc);
    vecs++;
    if ({busy, cur_flr} !== {1'b0, 4'b1000}) begin
      errs++; $display("FAIL rmid_top: got %b want %b", {busy, cur_flr}, 5'b01000);
    end
    req = 4'b0001;
    step();
    req = 4'b0110;
    step();
    req = '0;
    vecs++;
    if ({m_dn, pending} !== {1'b1, 4'b0111}) begin
      errs++; $display("FAIL rmid_pre: got %b want %b", {m_dn, pending}, 5'b10111);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({cur_flr, pending, dir, m_up, m_dn, door_open, arrive, busy} !== {4'b0001, 4'b0000, 1'b1, 5'b00000}) begin
      errs++; $display("FAIL rmid_async: got %b want %b", {cur_flr, pending, dir, m_up, m_dn, door_open, arrive, busy}, {4'b0001, 4'b0000, 1'b1, 5'b00000});
    end
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    vecs++;
    if ({busy, cur_flr, pending} !== {1'b0, 4'b0001, 4'b0000}) begin
      errs++; $display("FAIL rmid_after: got %b want %b", {busy, cur_flr, pending}, 9'b0_0001_0000);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    test_reset();
    test_same_floor();
    test_single_trip();
    test_scan();
    test_door_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
